// File: rtl/calculadora_multi_acumulador.sv
// rtl/calculadora_multi_acumulador.sv - NREGS x WIDTH accumulator calculator with shift-add multiply
module calculadora_multi_acumulador #(
    parameter int WIDTH    = 8,
    parameter int NREGS    = 4,
    parameter bit SATURATE = 1'b0,
    localparam int SELW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       codigo,
    input  logic [SELW-1:0]  sel,
    input  logic [WIDTH-1:0] entrada,
    output logic             out_valid,
    output logic [WIDTH-1:0] saida,
    output logic             overflow,
    output logic             busy
);
    localparam int CNTW = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, MUL} state_t;

    state_t               state, state_nx;
    logic [WIDTH-1:0]     acc [NREGS];
    logic                 accept, sel_ok, is_mul;
    logic [WIDTH-1:0]     a_cur;
    logic [WIDTH:0]       sum, diff;
    logic [WIDTH-1:0]     r_val;
    logic                 r_ovf, r_wr;
    logic [2*WIDTH-1:0]   m_a, m_p, p_nx;
    logic [WIDTH-1:0]     m_b;
    logic [SELW-1:0]      m_sel;
    logic [CNTW-1:0]      m_cnt;
    logic                 m_last, mul_ovf;
    logic [WIDTH-1:0]     mul_val;
    logic                 wr_en;
    logic [SELW-1:0]      wr_idx;
    logic [WIDTH-1:0]     wr_data;

    // Out-of-range selectors behave as NOP, so every index use is guarded by sel_ok.
    assign sel_ok = ({1'b0, sel} < (SELW + 1)'(NREGS));
    assign accept = in_valid && (state == IDLE);
    assign is_mul = (codigo == 4'b1000) && sel_ok;
    assign m_last = (m_cnt == CNTW'(WIDTH - 1));

    // Read port for the selected accumulator.
    always_comb begin
        a_cur = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (SELW'(i) == sel) a_cur = acc[i];
        end
    end

    // Single-cycle operation result; MUL and NOP leave everything at zero here.
    always_comb begin
        sum   = {1'b0, a_cur} + {1'b0, entrada};
        diff  = {1'b0, a_cur} - {1'b0, entrada};
        r_val = '0;
        r_ovf = 1'b0;
        r_wr  = 1'b0;
        if (sel_ok) begin
            case (codigo)
                4'b0000: r_val = entrada;
                4'b0001: begin
                    r_ovf = sum[WIDTH];
                    r_val = (SATURATE && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
                    r_wr  = 1'b1;
                end
                4'b0010: begin
                    r_ovf = diff[WIDTH];
                    r_val = (SATURATE && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
                    r_wr  = 1'b1;
                end
                4'b0011: r_val = a_cur;
                4'b0100: begin r_val = a_cur & entrada; r_wr = 1'b1; end
                4'b0101: begin r_val = a_cur | entrada; r_wr = 1'b1; end
                4'b0110: begin r_val = a_cur ^ entrada; r_wr = 1'b1; end
                4'b0111: begin r_val = '0; r_wr = 1'b1; end
                default: ;
            endcase
        end
    end

    // One shift-add step; on the last step this is the full product.
    always_comb begin
        p_nx    = m_b[0] ? (m_p + m_a) : m_p;
        mul_ovf = |p_nx[2*WIDTH-1:WIDTH];
        mul_val = (SATURATE && mul_ovf) ? '1 : p_nx[WIDTH-1:0];
    end

    // Accumulator write port shared by single-cycle ops and MUL completion.
    always_comb begin
        wr_en   = (state == IDLE) ? (accept && r_wr) : m_last;
        wr_idx  = (state == IDLE) ? sel : m_sel;
        wr_data = (state == IDLE) ? r_val : mul_val;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        in_ready = 1'b1;
        case (state)
            IDLE: if (accept && is_mul) state_nx = MUL;
            MUL: begin
                busy     = 1'b1;
                in_ready = 1'b0;
                if (m_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: accumulators, result registers and multiplier state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) acc[i] <= '0;
            saida     <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            m_a       <= '0;
            m_b       <= '0;
            m_p       <= '0;
            m_sel     <= '0;
            m_cnt     <= '0;
        end else begin
            out_valid <= 1'b0;
            if (wr_en) begin
                for (int i = 0; i < NREGS; i++) begin
                    if (SELW'(i) == wr_idx) acc[i] <= wr_data;
                end
            end
            if (state == IDLE) begin
                if (accept) begin
                    if (is_mul) begin
                        m_a   <= {{WIDTH{1'b0}}, a_cur};
                        m_b   <= entrada;
                        m_p   <= '0;
                        m_cnt <= '0;
                        m_sel <= sel;
                    end else begin
                        out_valid <= 1'b1;
                        saida     <= r_val;
                        overflow  <= r_ovf;
                    end
                end
            end else begin
                m_p   <= p_nx;
                m_a   <= m_a << 1;
                m_b   <= m_b >> 1;
                m_cnt <= m_cnt + 1'b1;
                if (m_last) begin
                    out_valid <= 1'b1;
                    saida     <= mul_val;
                    overflow  <= mul_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_calculadora_multi_acumulador.sv
// tb/tb_calculadora_multi_acumulador.sv - scoreboard bench for wrapping and saturating calculators
module tb_calculadora_multi_acumulador;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] codigo;
    logic [1:0] sel;
    logic [7:0] entrada;

    logic       rdy0, ov0v, of0, bz0;
    logic [7:0] sa0;
    logic       rdy1, ov1v, of1, bz1;
    logic [7:0] sa1;

    typedef struct {int r; int o;} exp_t;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   macc[2][4];
    int   checks = 0;
    int   errors = 0;

    calculadora_multi_acumulador #(.WIDTH(8), .NREGS(4), .SATURATE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .codigo(codigo),
        .sel(sel), .entrada(entrada), .out_valid(ov0v), .saida(sa0), .overflow(of0), .busy(bz0)
    );

    calculadora_multi_acumulador #(.WIDTH(8), .NREGS(4), .SATURATE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .codigo(codigo),
        .sel(sel), .entrada(entrada), .out_valid(ov1v), .saida(sa1), .overflow(of1), .busy(bz1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: plain integer arithmetic on an array of accumulators.
    function automatic void model(input int s, input int op, input int sl, input int e,
                                  output int r, output int o);
        int a;
        int t;
        a = macc[s][sl];
        r = 0;
        o = 0;
        case (op)
            0: r = e;
            1: begin t = a + e; o = (t > 255); r = o ? (s ? 255 : t - 256) : t; macc[s][sl] = r; end
            2: begin t = a - e; o = (t < 0);   r = o ? (s ? 0 : t + 256) : t;   macc[s][sl] = r; end
            3: r = a;
            4: begin r = a & e; macc[s][sl] = r; end
            5: begin r = a | e; macc[s][sl] = r; end
            6: begin r = a ^ e; macc[s][sl] = r; end
            7: begin r = 0; macc[s][sl] = 0; end
            8: begin t = a * e; o = (t > 255); r = o ? (s ? 255 : t % 256) : t; macc[s][sl] = r; end
            default: r = 0;
        endcase
    endfunction

    // Monitor: handshake consistency and scoreboard pops on every result pulse.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_vs_busy0", rdy0, !bz0);
            chk("ready_vs_busy1", rdy1, !bz1);
            if (ov0v) begin
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out_valid0 actual 1 expected 0 at %0t", $time);
                end else begin
                    e0 = q0.pop_front();
                    chk("saida0", sa0, e0.r);
                    chk("overflow0", of0, e0.o);
                end
            end
            if (ov1v) begin
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out_valid1 actual 1 expected 0 at %0t", $time);
                end else begin
                    e1 = q1.pop_front();
                    chk("saida1", sa1, e1.r);
                    chk("overflow1", of1, e1.o);
                end
            end
        end
    end

    task automatic issue(input int op, input int s, input int e);
        int   n;
        exp_t x;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        codigo   = 4'(op);
        sel      = 2'(s);
        entrada  = 8'(e);
        while (!rdy0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            errors++;
            $display("FAIL accept_timeout actual 0 expected 1 at %0t", $time);
            in_valid = 1'b0;
            return;
        end
        model(0, op, s, e, x.r, x.o);
        q0.push_back(x);
        model(1, op, s, e, x.r, x.o);
        q1.push_back(x);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 4; i++) macc[s][i] = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic mul_latency();
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("mul_busy", bz0, (k <= 8) ? 1 : 0);
            chk("mul_out_valid", ov0v, (k == 9) ? 1 : 0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        codigo   = '0;
        sel      = '0;
        entrada  = '0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 4; i++) macc[s][i] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_saida", sa0, 0);
        chk("reset_overflow", of0, 0);
        chk("reset_out_valid", ov0v, 0);
        chk("reset_busy", bz0, 0);
        chk("reset_in_ready", rdy0, 1);
        chk("reset_saida_sat", sa1, 0);

        // Carry out: wrap vs clamp.
        issue(1, 0, 200);
        issue(1, 0, 100);
        // Borrow: wrap vs clamp.
        do_reset();
        issue(2, 1, 5);

        // Multiply timing with a READ held behind it.
        issue(1, 2, 12);
        issue(8, 2, 11);
        fork
            issue(3, 2, 0);
            mul_latency();
        join
        issue(8, 2, 2);

        // Back-to-back across accumulators.
        issue(1, 0, 3);
        issue(1, 3, 7);
        issue(3, 0, 0);
        issue(3, 3, 0);

        // Reset mid-multiply.
        issue(8, 2, 9);
        repeat (3) @(negedge clk);
        do_reset();
        @(negedge clk);
        chk("abort_busy", bz0, 0);
        chk("abort_out_valid", ov0v, 0);
        issue(3, 2, 0);

        // Bitwise ops, PASS and an undefined opcode.
        do_reset();
        issue(1, 1, 8'hF0);
        issue(4, 1, 8'h3C);
        issue(6, 1, 8'hFF);
        issue(7, 1, 0);
        issue(1, 1, 8'h11);
        issue(0, 1, 8'h5A);
        issue(15, 1, 8'hAA);
        issue(3, 1, 0);

        // Random traffic.
        repeat (300) issue($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 255));

        repeat (20) @(negedge clk);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
